// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared constants and types for the MIPS multiply/divide unit.
//   OP_RTYPE        : opcode of all R-type instructions handled here
//   FN_*            : funct codes for mult/div and the HI/LO move ops
//   muldiv_state_t  : sequencer states (IDLE, CALC, FIX)
//   isRecognised()  : true when an opcode/funct pair belongs to this unit
package muldiv_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, CALC, FIX} muldiv_state_t;

  // Anything outside this set is invisible to the unit: no stall, no effect.
  function automatic logic isRecognised(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) &&
           (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                       FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational iteration of the sequential multiplier/divider.
//   isDiv_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i   : high accumulator (partial product high half / partial remainder)
//   mq_i    : multiplier-and-low-product, or dividend-and-quotient register
//   opnd_i  : multiplicand (mult) or divisor (div), both unsigned magnitudes
//   acc_o, mq_o : register values after this step
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: add the multiplicand when the current multiplier bit is set,
  // then shift {carry, acc, mq} right by one; the product fills in from the top.
  // Divide: shift the next dividend bit into the remainder and try subtracting
  // the divisor. The remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the top bit of the difference is a clean borrow.
  always_comb begin
    sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, mq_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};
    acc_o   = sum[WIDTH:1];
    mq_o    = {sum[0], mq_i[WIDTH-1:1]};
    if (isDiv_i) begin
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        mq_o  = {mq_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        mq_o  = {mq_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit with architectural HI/LO for the MIPS EX stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid_i             : instruction present in EX
//   opcode, funct       : R-type decode fields
//   rs_val, rt_val      : operands (dividend/multiplicand, divisor/multiplier)
//   flush_i             : abort any in-flight operation
//   stall_o             : hold EX while a recognised op waits on a busy unit
//   result_o            : registered mfhi/mflo data
//   result_valid_o      : one-cycle pulse qualifying result_o
//   busy_o              : mult/div in progress
//   hi_o, lo_o          : current HI/LO contents
// Build option: define MULDIV_FAST_MULT_EN to replace the iterative multiply
// with a single-cycle array multiplier (mult goes straight from IDLE to FIX).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  muldiv_state_t    state_q;
  logic [WIDTH-1:0] hi_q, lo_q, result_q;
  logic             resultValid_q;
  logic [WIDTH-1:0] acc_q, mq_q, opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             isDiv_q, negLo_q, negHi_q;

  logic             recognised, accept, signedOp, rsNeg, rtNeg;
  logic [WIDTH-1:0] rsAbs, rtAbs;
  logic [WIDTH-1:0] acc_d, mq_d;
  logic [WIDTH-1:0] fixHi_d, fixLo_d;
  logic [2*WIDTH-1:0] prodNeg;

  assign recognised     = valid_i & isRecognised(opcode, funct);
  assign busy_o         = (state_q != IDLE);
  assign stall_o        = recognised & busy_o & ~flush_i;
  assign accept         = recognised & ~busy_o & ~flush_i;
  assign result_o       = result_q;
  assign result_valid_o = resultValid_q;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;

  // The datapath works on magnitudes; signs are reapplied in FIX.
  assign signedOp = (funct == FN_MULT) | (funct == FN_DIV);
  assign rsNeg    = signedOp & rs_val[WIDTH-1];
  assign rtNeg    = signedOp & rt_val[WIDTH-1];
  assign rsAbs    = rsNeg ? -rs_val : rs_val;
  assign rtAbs    = rtNeg ? -rt_val : rt_val;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fastProd;
  assign fastProd = {{WIDTH{1'b0}}, rsAbs} * {{WIDTH{1'b0}}, rtAbs};
`endif

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .isDiv_i (isDiv_q),
    .acc_i   (acc_q),
    .mq_i    (mq_q),
    .opnd_i  (opnd_q),
    .acc_o   (acc_d),
    .mq_o    (mq_d)
  );

  // Sign correction: the product is negated as one 2*WIDTH value; for divide
  // the quotient follows the XOR of signs, the remainder follows the dividend.
  always_comb begin
    fixHi_d = acc_q;
    fixLo_d = mq_q;
    prodNeg = -{acc_q, mq_q};
    if (isDiv_q) begin
      if (negLo_q) fixLo_d = -mq_q;
      if (negHi_q) fixHi_d = -acc_q;
    end else if (negLo_q) begin
      {fixHi_d, fixLo_d} = prodNeg;
    end
  end

  // Sequencer, HI/LO and result registers. Flush wins over everything and
  // leaves HI/LO untouched. A divide by zero preloads HI <- rs and LO <- ones
  // with sign correction disabled and goes straight to FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      acc_q         <= '0;
      mq_q          <= '0;
      opnd_q        <= '0;
      cnt_q         <= '0;
      isDiv_q       <= 1'b0;
      negLo_q       <= 1'b0;
      negHi_q       <= 1'b0;
    end else begin
      resultValid_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              case (funct)
                FN_MTHI: hi_q <= rs_val;
                FN_MTLO: lo_q <= rs_val;
                FN_MFHI: begin
                  result_q      <= hi_q;
                  resultValid_q <= 1'b1;
                end
                FN_MFLO: begin
                  result_q      <= lo_q;
                  resultValid_q <= 1'b1;
                end
                FN_MULT, FN_MULTU: begin
                  isDiv_q <= 1'b0;
                  negLo_q <= rsNeg ^ rtNeg;
                  negHi_q <= 1'b0;
                  opnd_q  <= rsAbs;
                  cnt_q   <= '0;
`ifdef MULDIV_FAST_MULT_EN
                  {acc_q, mq_q} <= fastProd;
                  state_q       <= FIX;
`else
                  acc_q   <= '0;
                  mq_q    <= rtAbs;
                  state_q <= CALC;
`endif
                end
                FN_DIV, FN_DIVU: begin
                  isDiv_q <= 1'b1;
                  cnt_q   <= '0;
                  opnd_q  <= rtAbs;
                  if (rt_val == '0) begin
                    acc_q   <= rs_val;
                    mq_q    <= '1;
                    negLo_q <= 1'b0;
                    negHi_q <= 1'b0;
                    state_q <= FIX;
                  end else begin
                    acc_q   <= '0;
                    mq_q    <= rsAbs;
                    negLo_q <= rsNeg ^ rtNeg;
                    negHi_q <= rsNeg;
                    state_q <= CALC;
                  end
                end
                default: ;
              endcase
            end
          end
          CALC: begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
          end
          FIX: begin
            hi_q    <= fixHi_d;
            lo_q    <= fixLo_d;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed bench for muldiv_unit at WIDTH=32: a vector table of mult/div ops
// with hand-computed HI/LO and busy lengths, then hand-written sequences for
// stall/mfhi interlock, flush, asynchronous reset and ignored encodings.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MULT_BUSY = 1;
`else
  localparam int MULT_BUSY = 33;
`endif

  logic        clk, rst_n, valid, flush;
  logic [5:0]  opcode, funct;
  logic [31:0] rsVal, rtVal;
  logic        stall, resultValid, busy;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int fails  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid),
    .opcode         (opcode),
    .funct          (funct),
    .rs_val         (rsVal),
    .rt_val         (rtVal),
    .flush_i        (flush),
    .stall_o        (stall),
    .result_o       (result),
    .result_valid_o (resultValid),
    .busy_o         (busy),
    .hi_o           (hi),
    .lo_o           (lo)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expBusy;
  } vec_t;

  vec_t vecQ[$];

  logic        stallAt[0:40];
  logic        rvAt[0:40];
  logic        busyAt[0:40];
  logic [31:0] resAt[0:40];

  task automatic addVec(input string nm, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int eb);
    vec_t v;
    v.name = nm; v.fn = fn; v.rs = a; v.rt = b;
    v.expHi = eh; v.expLo = el; v.expBusy = eb;
    vecQ.push_back(v);
  endtask

  // Present one op for exactly one cycle (cycle 0); returns mid-cycle 1.
  task automatic applyStimulus(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid = 1'b1; opcode = OP_RTYPE; funct = fn; rsVal = a; rtVal = b;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic checkOutput(input string nm, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, actual, expected);
    end
  endtask

  initial begin
    int n;
    int sc;
    int badCnt;
    logic [31:0] loSave;

    clk = 1'b0; rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
    opcode = '0; funct = '0; rsVal = '0; rtVal = '0;

    addVec("mult_neg3x7",   FN_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MULT_BUSY);
    addVec("multu_maxx2",   FN_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MULT_BUSY);
    addVec("mult_minxmin",  FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_BUSY);
    addVec("divu_100_7",    FN_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33);
    addVec("div_neg7_2",    FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    addVec("div_7_neg2",    FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
    addVec("div_min_neg1",  FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    addVec("div_by_zero",   FN_DIV,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1);
    addVec("divu_0_by_0",   FN_DIVU,  32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 1);
    addVec("multu_0xF",     FN_MULTU, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, MULT_BUSY);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_hi",    64'(hi), 64'h0);
    checkOutput("reset_lo",    64'(lo), 64'h0);
    checkOutput("reset_busy",  64'(busy), 64'h0);
    checkOutput("reset_rv",    64'(resultValid), 64'h0);
    checkOutput("reset_res",   64'(result), 64'h0);
    rst_n = 1'b1;

    // Table-driven mult/div vectors: busy length and resulting HI/LO
    for (int i = 0; i < vecQ.size(); i++) begin
      applyStimulus(vecQ[i].fn, vecQ[i].rs, vecQ[i].rt);
      n = 0;
      while (busy && n < 200) begin
        n++;
        @(negedge clk);
      end
      checkOutput({vecQ[i].name, "_busy"}, 64'(n), 64'(vecQ[i].expBusy));
      checkOutput({vecQ[i].name, "_hi"}, 64'(hi), 64'(vecQ[i].expHi));
      checkOutput({vecQ[i].name, "_lo"}, 64'(lo), 64'(vecQ[i].expLo));
    end

    // Mult held valid (repeats stall), then mfhi waiting from cycle 5
    @(negedge clk);
    valid = 1'b1; opcode = OP_RTYPE; funct = FN_MULT; rsVal = 32'hFFFFFFFD; rtVal = 32'd7;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (c == 5) funct = FN_MFHI;
      #1;
      stallAt[c] = stall; rvAt[c] = resultValid; resAt[c] = result; busyAt[c] = busy;
      if (c == MULT_BUSY + 2) valid = 1'b0;
    end
    sc = 0;
    for (int c = 1; c <= MULT_BUSY; c++) if (stallAt[c]) sc++;
    checkOutput("seqA_stall_cycles", 64'(sc), 64'(MULT_BUSY));
    checkOutput("seqA_busy_last",    64'(busyAt[MULT_BUSY]), 64'h1);
    checkOutput("seqA_stall_clear",  64'(stallAt[MULT_BUSY + 1]), 64'h0);
    checkOutput("seqA_rv_early",     64'(rvAt[MULT_BUSY + 1]), 64'h0);
    checkOutput("seqA_rv_pulse",     64'(rvAt[MULT_BUSY + 2]), 64'h1);
    checkOutput("seqA_mfhi_data",    64'(resAt[MULT_BUSY + 2]), 64'hFFFFFFFF);
    checkOutput("seqA_rv_single",    64'(rvAt[MULT_BUSY + 3]), 64'h0);
    applyStimulus(FN_MFLO, 32'd0, 32'd0);
    checkOutput("seqA_mflo_rv",   64'(resultValid), 64'h1);
    checkOutput("seqA_mflo_data", 64'(result), 64'hFFFFFFEB);

    // mthi, then a multu flushed in cycle 10 with an mflo waiting behind it
    applyStimulus(FN_MTHI, 32'hAAAA5555, 32'd0);
    checkOutput("seqB_mthi", 64'(hi), 64'hAAAA5555);
    loSave = lo;
    @(negedge clk);
    valid = 1'b1; opcode = OP_RTYPE; funct = FN_MULTU; rsVal = 32'd5; rtVal = 32'd6;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 3)  funct = FN_MFLO;
      if (c == 10) flush = 1'b1;
      if (c == 11) flush = 1'b0;
      #1;
      stallAt[c] = stall; rvAt[c] = resultValid; resAt[c] = result; busyAt[c] = busy;
      if (c == 12) valid = 1'b0;
    end
    checkOutput("seqB_stall_before", 64'(stallAt[9]), 64'h1);
    checkOutput("seqB_stall_flush",  64'(stallAt[10]), 64'h0);
    checkOutput("seqB_busy_flush",   64'(busyAt[10]), 64'h1);
    checkOutput("seqB_busy_after",   64'(busyAt[11]), 64'h0);
    checkOutput("seqB_stall_after",  64'(stallAt[11]), 64'h0);
    checkOutput("seqB_rv_flush",     64'(rvAt[11]), 64'h0);
    checkOutput("seqB_rv_mflo",      64'(rvAt[12]), 64'h1);
    checkOutput("seqB_mflo_data",    64'(resAt[12]), 64'(loSave));
    checkOutput("seqB_hi_kept",      64'(hi), 64'hAAAA5555);

    // Asynchronous reset in cycle 15 of a divide
    @(negedge clk);
    valid = 1'b1; opcode = OP_RTYPE; funct = FN_DIV; rsVal = 32'd1000; rtVal = 32'd3;
    @(negedge clk);
    valid = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("seqC_busy", 64'(busy), 64'h0);
    checkOutput("seqC_hi",   64'(hi), 64'h0);
    checkOutput("seqC_lo",   64'(lo), 64'h0);
    checkOutput("seqC_rv",   64'(resultValid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unrecognised funct and non-R-type opcode are ignored
    badCnt = 0;
    valid = 1'b1; opcode = OP_RTYPE; funct = 6'h20; rsVal = 32'h1234; rtVal = 32'h5678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin opcode = 6'h08; funct = FN_MULT; end
      #1;
      if (stall || resultValid || busy) badCnt++;
    end
    valid = 1'b0;
    checkOutput("seqD_ignored",  64'(badCnt), 64'h0);
    checkOutput("seqD_hi_clean", 64'(hi), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
